// File: rtl/current_monitor.sv
// rtl/current_monitor.sv - moving-average current monitor with overcurrent trip (optional peak: CURRENT_MONITOR_PEAK_EN)
module current_monitor #(
    parameter int AVG_LOG2 = 3,
    parameter int OC_LIMIT = 2000,
    parameter int OC_COUNT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] current_in,
    input  logic               current_valid,
    input  logic               fault_clear,
    output logic signed [15:0] current_avg,
    output logic               avg_valid,
    output logic               overcurrent,
`ifdef CURRENT_MONITOR_PEAK_EN
    output logic [15:0]        peak,
`endif
    output logic               fault
);

    localparam int              DEPTH    = 1 << AVG_LOG2;
    localparam int              SW       = 16 + AVG_LOG2;
    localparam logic [15:0]     OC_LIM16 = 16'(OC_LIMIT);
    localparam logic [7:0]      OC_CNT8  = 8'(OC_COUNT);

    typedef enum logic {
        AVG_FILL,
        AVG_RUN
    } avg_state_t;

    typedef enum logic [1:0] {
        F_OK,
        F_PENDING,
        F_TRIPPED
    } fault_state_t;

    // Averager storage and bookkeeping
    logic signed [15:0]   ring [DEPTH];
    logic [AVG_LOG2-1:0]  wptr;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] sum_next;
    logic signed [15:0]   oldest;
    logic                 last_slot;
    logic                 publish;
    avg_state_t           avg_state;
    avg_state_t           avg_state_next;

    // Overcurrent qualification
    logic [15:0]          mag;
    logic                 over;
    logic [7:0]           over_cnt;
    logic [7:0]           over_cnt_inc;
    logic [7:0]           over_cnt_next;
    logic                 tripping;
    fault_state_t         fault_state;
    fault_state_t         fault_state_next;

    // Oldest entry is forced to zero while filling so the sum is exact at the boundary
    always_comb begin
        oldest    = (avg_state == AVG_FILL) ? 16'sd0 : ring[wptr];
        last_slot = (wptr == AVG_LOG2'(DEPTH - 1));
        sum_next  = sum
                  + {{AVG_LOG2{current_in[15]}}, current_in}
                  - {{AVG_LOG2{oldest[15]}}, oldest};
        publish   = current_valid && ((avg_state == AVG_RUN) || last_slot);
    end

    // Averager state register
    always_ff @(posedge clk) begin
        if (reset) begin
            avg_state <= AVG_FILL;
        end else begin
            avg_state <= avg_state_next;
        end
    end

    // Averager next state: FILL until the last ring slot is first written
    always_comb begin
        avg_state_next = avg_state;
        case (avg_state)
            AVG_FILL: if (current_valid && last_slot) avg_state_next = AVG_RUN;
            AVG_RUN:  avg_state_next = AVG_RUN;
            default:  avg_state_next = AVG_FILL;
        endcase
    end

    // Ring buffer, running sum and published average
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring[i] <= '0;
            end
            wptr        <= '0;
            sum         <= '0;
            current_avg <= '0;
            avg_valid   <= 1'b0;
        end else begin
            avg_valid <= publish;
            if (current_valid) begin
                ring[wptr] <= current_in;
                wptr       <= wptr + 1'b1;
                sum        <= sum_next;
            end
            if (publish) begin
                current_avg <= 16'(sum_next >>> AVG_LOG2);
            end
        end
    end

    // Saturating magnitude: -32768 has no positive counterpart in 16 bits
    always_comb begin
        if (current_in == 16'sh8000) begin
            mag = 16'h7fff;
        end else if (current_in[15]) begin
            mag = -current_in;
        end else begin
            mag = current_in;
        end
        over = (mag > OC_LIM16);
    end

    // Overcurrent flag follows the latest sample and holds in between
    always_ff @(posedge clk) begin
        if (reset) begin
            overcurrent <= 1'b0;
        end else if (current_valid) begin
            overcurrent <= over;
        end
    end

    // Fault state register and consecutive-over counter
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_state <= F_OK;
            over_cnt    <= '0;
        end else begin
            fault_state <= fault_state_next;
            over_cnt    <= over_cnt_next;
        end
    end

    // Fault next state: a tripping sample beats a coincident fault_clear
    always_comb begin
        fault_state_next = fault_state;
        over_cnt_next    = over_cnt;
        over_cnt_inc     = over_cnt + 8'd1;
        tripping         = (fault_state != F_TRIPPED) && current_valid && over
                           && (over_cnt_inc >= OC_CNT8);
        case (fault_state)
            F_OK, F_PENDING: begin
                if (current_valid) begin
                    if (over) begin
                        over_cnt_next    = over_cnt_inc;
                        fault_state_next = tripping ? F_TRIPPED : F_PENDING;
                    end else begin
                        over_cnt_next    = '0;
                        fault_state_next = F_OK;
                    end
                end
            end
            F_TRIPPED: fault_state_next = F_TRIPPED;
            default: begin
                fault_state_next = F_OK;
                over_cnt_next    = '0;
            end
        endcase
        if (fault_clear && !tripping) begin
            fault_state_next = F_OK;
            over_cnt_next    = '0;
        end
    end

    assign fault = (fault_state == F_TRIPPED);

`ifdef CURRENT_MONITOR_PEAK_EN
    // Peak magnitude; a sample in the same cycle as fault_clear keeps the peak alive
    always_ff @(posedge clk) begin
        if (reset) begin
            peak <= '0;
        end else if (current_valid) begin
            if (mag > peak) peak <= mag;
        end else if (fault_clear) begin
            peak <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_current_monitor.sv
// tb/tb_current_monitor.sv - self-checking bench for current_monitor
module tb_current_monitor;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [15:0] current_in = '0;
    logic               current_valid = 1'b0;
    logic               fault_clear = 1'b0;
    logic signed [15:0] current_avg;
    logic               avg_valid;
    logic               overcurrent;
    logic               fault;
`ifdef CURRENT_MONITOR_PEAK_EN
    logic [15:0]        peak;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state
    int win[$];
    int nsamp;
    int exp_avg;
    int exp_avgv;
    int exp_oc;
    int run_len;
    int tripped;
    int exp_peak;

    always #5 clk = ~clk;

    current_monitor #(.AVG_LOG2(3), .OC_LIMIT(2000), .OC_COUNT(4)) dut (
        .clk(clk),
        .reset(reset),
        .current_in(current_in),
        .current_valid(current_valid),
        .fault_clear(fault_clear),
        .current_avg(current_avg),
        .avg_valid(avg_valid),
        .overcurrent(overcurrent),
`ifdef CURRENT_MONITOR_PEAK_EN
        .peak(peak),
`endif
        .fault(fault)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int floor_div8(input int s);
        int q;
        q = s / 8;
        if ((s % 8) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_step(input bit r, input bit v, input int d, input bit c);
        int mag;
        int total;
        bit trip_now;
        if (r) begin
            win.delete();
            nsamp = 0; exp_avg = 0; exp_avgv = 0; exp_oc = 0;
            run_len = 0; tripped = 0; exp_peak = 0;
            return;
        end
        exp_avgv = 0;
        trip_now = 0;
        mag = (d == -32768) ? 32767 : ((d < 0) ? -d : d);
        if (v) begin
            win.push_back(d);
            if (win.size() > 8) void'(win.pop_front());
            nsamp++;
            if (nsamp >= 8) begin
                total = 0;
                foreach (win[i]) total += win[i];
                exp_avg  = floor_div8(total);
                exp_avgv = 1;
            end
            exp_oc = (mag > 2000) ? 1 : 0;
            if (!tripped) begin
                run_len = (mag > 2000) ? run_len + 1 : 0;
                if (run_len >= 4) begin
                    tripped  = 1;
                    trip_now = 1;
                end
            end
            if (mag > exp_peak) exp_peak = mag;
        end
        if (c && !trip_now) begin
            tripped = 0;
            run_len = 0;
            if (!v) exp_peak = 0;
        end
    endtask

    task automatic compare_all();
        chk("avg_valid", avg_valid, exp_avgv);
        chk("current_avg", current_avg, exp_avg);
        chk("overcurrent", overcurrent, exp_oc);
        chk("fault", fault, tripped);
`ifdef CURRENT_MONITOR_PEAK_EN
        chk("peak", peak, exp_peak);
`endif
    endtask

    // One clock: apply inputs, advance, update model, compare everything
    task automatic drive(input bit r, input bit v, input logic signed [15:0] d, input bit c);
        reset = r; current_valid = v; current_in = d; fault_clear = c;
        @(posedge clk);
        #1;
        model_step(r, v, int'(d), c);
        compare_all();
        reset = 1'b0; current_valid = 1'b0; fault_clear = 1'b0; current_in = '0;
    endtask

    initial begin
        int d;
        bit v, c, r;

        // Reset state
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        chk("reset_avg", current_avg, 0);
        chk("reset_fault", fault, 0);

        // Fill with 100s: no avg_valid until the eighth sample
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, 16'sd100, 0);
            chk("fill_no_valid", avg_valid, 0);
        end
        drive(0, 1, 16'sd100, 0);
        chk("fill_done_valid", avg_valid, 1);
        chk("fill_done_avg", current_avg, 100);
        drive(0, 0, 0, 0);
        chk("avg_valid_one_cycle", avg_valid, 0);

        // Negative sample enters and is later evicted after pointer wrap
        drive(0, 1, -16'sd700, 0);
        chk("neg_avg", current_avg, 0);
        for (int i = 0; i < 7; i++) drive(0, 1, 16'sd100, 0);
        chk("neg_still_in", current_avg, 0);
        drive(0, 1, 16'sd100, 0);
        chk("neg_evicted", current_avg, 100);
        drive(0, 1, 16'sd100, 0);
        chk("after_wrap", current_avg, 100);

        // Trip needs four consecutive over-limit samples
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 16'sd2001, 0);
        chk("oc_tracks", overcurrent, 1);
        drive(0, 1, 16'sd0, 0);
        chk("oc_drops", overcurrent, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 16'sd2001, 0);
            chk("no_trip_yet", fault, 0);
        end
        drive(0, 1, 16'sd2001, 0);
        chk("tripped", fault, 1);
        drive(0, 1, 16'sd0, 0);
        chk("tripped_holds", fault, 1);

        // Clear, then clear coinciding with a tripping sample
        drive(0, 0, 0, 1);
        chk("cleared", fault, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 16'sd2001, 0);
        drive(0, 1, 16'sd2001, 1);
        chk("trip_beats_clear", fault, 1);
        drive(0, 0, 0, 1);

        // Most negative sample saturates
        drive(0, 1, -16'sd32768, 0);
        chk("min_oc", overcurrent, 1);
`ifdef CURRENT_MONITOR_PEAK_EN
        chk("min_peak", peak, 32767);
`endif

        // Reset mid-fill, with valid and clear also asserted
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 16'sd3000, 0);
        drive(1, 1, 16'sd3000, 1);
        chk("midfill_avg", current_avg, 0);
        chk("midfill_oc", overcurrent, 0);
        for (int i = 0; i < 7; i++) drive(0, 1, 16'sd40, 0);
        chk("restart_no_valid", avg_valid, 0);
        drive(0, 1, 16'sd40, 0);
        chk("restart_valid", avg_valid, 1);
        chk("restart_avg", current_avg, 40);

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            v = ($urandom_range(0, 9) < 6);
            c = ($urandom_range(0, 29) == 0);
            r = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 9))
                0:       d = -32768;
                1:       d = 32767;
                2, 3, 4: d = int'($urandom_range(0, 1000)) + 2001;
                default: d = int'($urandom_range(0, 8000)) - 4000;
            endcase
            drive(r, v, 16'(d), c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
